// File: rtl/uart_fifo_arbiter_if.sv
// Requester-side bus of the UART transmit FIFO write arbiter.
//   req      : per-requester word valid
//   req_data : requester i's word occupies bits [i*WIDTH +: WIDTH]
//   lock     : per-requester burst-lock request, qualified with req
//   gnt      : one-hot accept returned by the arbiter (combinational)
// The requesters drive through the master modport; the arbiter uses slave.
interface uart_fifo_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 4
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       lock;
    logic [NREQ-1:0]       gnt;

    modport master (output req, output req_data, output lock, input gnt);
    modport slave  (input req, input req_data, input lock, output gnt);
endinterface

// File: rtl/uart_fifo_arbiter.sv
// Round-robin write arbiter and occupancy tracker in front of the UART TX FIFO.
// Grants at most one requester word per cycle, forwards it to the FIFO through
// registered write/data, tracks FIFO occupancy from read-side pops, and holds
// a locked burst owner so multi-word messages are not interleaved.
// Ports:
//   clk, reset    : rising-edge clock, asynchronous active-low reset
//   req_if        : requester bus (req, req_data, lock in; gnt out)
//   overwrite_en  : 1 = accept while full (FIFO drops oldest), 0 = stall
//   fifo_pop      : one pulse per word removed by the FIFO read side
//   fifo_write    : registered write strobe, fifo_data: registered word
//   count/full/empty : accepted-not-popped words incl. in-flight write
//   ovf_cnt       : saturating count of overwrite accepts
//   locked/owner  : burst lock active and its owner
module uart_fifo_arbiter #(
    parameter int WIDTH     = 32,
    parameter int NREQ      = 4,
    parameter int DEPTH     = 16,
    parameter int MAX_BURST = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    uart_fifo_arbiter_if.slave      req_if,
    input  logic                    overwrite_en,
    input  logic                    fifo_pop,
    output logic                    fifo_write,
    output logic [WIDTH-1:0]        fifo_data,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty,
    output logic [7:0]              ovf_cnt,
    output logic                    locked,
    output logic [$clog2(NREQ)-1:0] owner
);
    localparam int PW = $clog2(NREQ);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [0:0] {ST_ARB = 1'b0, ST_LOCKED = 1'b1} state_e;

    state_e            state_q, state_d;
    logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]     owner_q, owner_d;
    logic [BW-1:0]     burst_q, burst_d;
    logic              fifo_write_q, fifo_write_d;
    logic [WIDTH-1:0]  fifo_data_q, fifo_data_d;
    logic [CW-1:0]     count_q, count_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic [7:0]        ovf_q, ovf_d;

    logic [NREQ-1:0]   gnt_s;
    logic [PW-1:0]     gnt_idx_s;
    logic              space_s;
    logic              lock_hold_s;
    logic              accept_s;
    logic              pop_ok_s;

    // Grant decision: locked owner only, otherwise circular search from rr_ptr.
    always_comb begin : grant_logic
        logic          found_v;
        logic [PW-1:0] idx_v;
        found_v     = 1'b0;
        idx_v       = {PW{1'b0}};
        gnt_s       = {NREQ{1'b0}};
        gnt_idx_s   = {PW{1'b0}};
        space_s     = !full_q || overwrite_en;
        // The lock survives only while the owner keeps both req and lock high;
        // otherwise this very cycle is arbitrated normally. rr_ptr already
        // equals owner+1 throughout a burst.
        lock_hold_s = (state_q == ST_LOCKED) && req_if.req[owner_q] && req_if.lock[owner_q];
        if (!space_s) begin
            gnt_s = {NREQ{1'b0}};
        end else if (lock_hold_s) begin
            gnt_s[owner_q] = 1'b1;
            gnt_idx_s      = owner_q;
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                idx_v = PW'((int'(rr_ptr_q) + k) % NREQ);
                if (!found_v && req_if.req[idx_v]) begin
                    found_v          = 1'b1;
                    gnt_s[idx_v]     = 1'b1;
                    gnt_idx_s        = idx_v;
                end else begin
                    found_v = found_v;
                end
            end
        end
    end

    assign req_if.gnt = gnt_s;
    assign accept_s   = |gnt_s;
    // Subtracting the in-flight write keeps a pop of an empty FIFO from
    // cancelling a word that has not reached the FIFO yet.
    assign pop_ok_s   = fifo_pop && (count_q > CW'(fifo_write_q));

    // Next-state: write path, round-robin pointer, lock FSM, occupancy.
    always_comb begin : next_state
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        owner_d      = owner_q;
        burst_d      = burst_q;
        fifo_write_d = accept_s;
        fifo_data_d  = fifo_data_q;
        count_d      = count_q;
        ovf_d        = ovf_q;

        if (accept_s) begin
            fifo_data_d = req_if.req_data[gnt_idx_s*WIDTH +: WIDTH];
            rr_ptr_d    = (gnt_idx_s == PW'(NREQ - 1)) ? {PW{1'b0}} : gnt_idx_s + PW'(1);
        end else begin
            fifo_data_d = fifo_data_q;
        end

        if (lock_hold_s) begin
            if (!accept_s) begin
                state_d = ST_LOCKED;
            end else if (burst_q == BW'(MAX_BURST - 1)) begin
                state_d = ST_ARB;
                burst_d = {BW{1'b0}};
            end else begin
                burst_d = burst_q + BW'(1);
            end
        end else if (accept_s && req_if.lock[gnt_idx_s] && (MAX_BURST > 1)) begin
            state_d = ST_LOCKED;
            owner_d = gnt_idx_s;
            burst_d = BW'(1);
        end else begin
            state_d = ST_ARB;
            burst_d = {BW{1'b0}};
        end

        if (accept_s && !pop_ok_s) begin
            if (full_q) begin
                // Overwrite: the FIFO drops its oldest entry, occupancy stays full.
                ovf_d = (ovf_q == 8'hFF) ? ovf_q : ovf_q + 8'd1;
            end else begin
                count_d = count_q + CW'(1);
            end
        end else if (!accept_s && pop_ok_s) begin
            count_d = count_q - CW'(1);
        end else begin
            count_d = count_q;
        end

        full_d  = (count_d == DEPTH_C);
        empty_d = (count_d == {CW{1'b0}});
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_ARB;
            rr_ptr_q     <= {PW{1'b0}};
            owner_q      <= {PW{1'b0}};
            burst_q      <= {BW{1'b0}};
            fifo_write_q <= 1'b0;
            fifo_data_q  <= {WIDTH{1'b0}};
            count_q      <= {CW{1'b0}};
            full_q       <= 1'b0;
            empty_q      <= 1'b1;
            ovf_q        <= 8'd0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            owner_q      <= owner_d;
            burst_q      <= burst_d;
            fifo_write_q <= fifo_write_d;
            fifo_data_q  <= fifo_data_d;
            count_q      <= count_d;
            full_q       <= full_d;
            empty_q      <= empty_d;
            ovf_q        <= ovf_d;
        end
    end

    assign fifo_write = fifo_write_q;
    assign fifo_data  = fifo_data_q;
    assign count      = count_q;
    assign full       = full_q;
    assign empty      = empty_q;
    assign ovf_cnt    = ovf_q;
    assign locked     = (state_q == ST_LOCKED);
    assign owner      = owner_q;
endmodule

// File: tb/tb_uart_fifo_arbiter.sv
module tb_uart_fifo_arbiter;
    localparam int WIDTH     = 32;
    localparam int NREQ      = 4;
    localparam int DEPTH     = 16;
    localparam int MAX_BURST = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              overwrite_en;
    logic              fifo_pop;
    logic              fifo_write;
    logic [WIDTH-1:0]  fifo_data;
    logic [4:0]        count;
    logic              full;
    logic              empty;
    logic [7:0]        ovf_cnt;
    logic              locked;
    logic [1:0]        owner;

    always #5 clk = ~clk;

    uart_fifo_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

    uart_fifo_arbiter #(
        .WIDTH(WIDTH), .NREQ(NREQ), .DEPTH(DEPTH), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk(clk), .reset(reset), .req_if(bus),
        .overwrite_en(overwrite_en), .fifo_pop(fifo_pop),
        .fifo_write(fifo_write), .fifo_data(fifo_data),
        .count(count), .full(full), .empty(empty),
        .ovf_cnt(ovf_cnt), .locked(locked), .owner(owner)
    );

    typedef struct {
        logic [3:0] req;
        logic [3:0] lock;
        logic       pop;
        logic       ovf_en;
        logic [3:0] gnt;
        int         cnt;
        logic       lk;
        int         own;
        int         ovf;
    } vec_t;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    vec_t tbl[19];

    function automatic vec_t mk(input logic [3:0] r, input logic [3:0] l, input logic p,
                                input logic o, input logic [3:0] g, input int c,
                                input logic lk, input int ov);
        vec_t v;
        v.req = r; v.lock = l; v.pop = p; v.ovf_en = o; v.gnt = g;
        v.cnt = c; v.lk = lk; v.own = 1; v.ovf = ov;
        return v;
    endfunction

    function automatic logic [31:0] word(input int c, input int i);
        return {8'hA5, 8'(c), 8'h3C, 8'(i)};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // One cycle: drive at negedge, check gnt before the edge, registered outputs after.
    task automatic apply(input vec_t v, input string nm);
        int idx;
        @(negedge clk);
        cyc++;
        bus.req      = v.req;
        bus.lock     = v.lock;
        fifo_pop     = v.pop;
        overwrite_en = v.ovf_en;
        for (int i = 0; i < NREQ; i++) bus.req_data[i*WIDTH +: WIDTH] = word(cyc, i);
        #1;
        check({nm, ".gnt"}, 32'(bus.gnt), 32'(v.gnt));
        @(posedge clk);
        #1;
        check({nm, ".count"}, 32'(count), 32'(v.cnt));
        check({nm, ".full"}, 32'(full), 32'(v.cnt == DEPTH));
        check({nm, ".empty"}, 32'(empty), 32'(v.cnt == 0));
        check({nm, ".fifo_write"}, 32'(fifo_write), 32'(v.gnt != 4'b0000));
        check({nm, ".locked"}, 32'(locked), 32'(v.lk));
        check({nm, ".ovf_cnt"}, 32'(ovf_cnt), 32'(v.ovf));
        if (v.lk) check({nm, ".owner"}, 32'(owner), 32'(v.own));
        if (v.gnt != 4'b0000) begin
            idx = 0;
            for (int i = 0; i < NREQ; i++) if (v.gnt[i]) idx = i;
            check({nm, ".fifo_data"}, fifo_data, word(cyc, idx));
        end
    endtask

    initial begin
        bus.req = 4'b0000; bus.lock = 4'b0000; bus.req_data = '0;
        overwrite_en = 1'b0; fifo_pop = 1'b0;

        // Round robin from reset, 8 cycles of all requests, no pops.
        tbl[0]  = mk(4'b1111, 4'b0000, 1'b0, 1'b0, 4'b0001, 1, 1'b0, 0);
        tbl[1]  = mk(4'b1111, 4'b0000, 1'b0, 1'b0, 4'b0010, 2, 1'b0, 0);
        tbl[2]  = mk(4'b1111, 4'b0000, 1'b0, 1'b0, 4'b0100, 3, 1'b0, 0);
        tbl[3]  = mk(4'b1111, 4'b0000, 1'b0, 1'b0, 4'b1000, 4, 1'b0, 0);
        tbl[4]  = mk(4'b1111, 4'b0000, 1'b0, 1'b0, 4'b0001, 5, 1'b0, 0);
        tbl[5]  = mk(4'b1111, 4'b0000, 1'b0, 1'b0, 4'b0010, 6, 1'b0, 0);
        tbl[6]  = mk(4'b1111, 4'b0000, 1'b0, 1'b0, 4'b0100, 7, 1'b0, 0);
        tbl[7]  = mk(4'b1111, 4'b0000, 1'b0, 1'b0, 4'b1000, 8, 1'b0, 0);
        // Move rr_ptr to 1, then locked burst of 4 from requester 1 (pops keep count at 8).
        tbl[8]  = mk(4'b0001, 4'b0000, 1'b1, 1'b0, 4'b0001, 8, 1'b0, 0);
        tbl[9]  = mk(4'b1011, 4'b0010, 1'b1, 1'b0, 4'b0010, 8, 1'b1, 0);
        tbl[10] = mk(4'b1011, 4'b0010, 1'b1, 1'b0, 4'b0010, 8, 1'b1, 0);
        tbl[11] = mk(4'b1011, 4'b0010, 1'b1, 1'b0, 4'b0010, 8, 1'b1, 0);
        tbl[12] = mk(4'b1011, 4'b0010, 1'b1, 1'b0, 4'b0010, 8, 1'b0, 0);
        tbl[13] = mk(4'b1011, 4'b0000, 1'b1, 1'b0, 4'b1000, 8, 1'b0, 0);
        tbl[14] = mk(4'b1011, 4'b0000, 1'b1, 1'b0, 4'b0001, 8, 1'b0, 0);
        // Early unlock after 2 locked accepts: same cycle arbitrates from 2 -> requester 3.
        tbl[15] = mk(4'b1011, 4'b0010, 1'b1, 1'b0, 4'b0010, 8, 1'b1, 0);
        tbl[16] = mk(4'b1011, 4'b0010, 1'b1, 1'b0, 4'b0010, 8, 1'b1, 0);
        tbl[17] = mk(4'b1011, 4'b0000, 1'b1, 1'b0, 4'b1000, 8, 1'b0, 0);
        tbl[18] = mk(4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 7, 1'b0, 0);

        repeat (2) @(posedge clk);
        #1;
        check("reset.count", 32'(count), 32'd0);
        check("reset.empty", 32'(empty), 32'd1);
        check("reset.full", 32'(full), 32'd0);
        check("reset.fifo_write", 32'(fifo_write), 32'd0);
        check("reset.fifo_data", fifo_data, 32'd0);
        check("reset.ovf_cnt", 32'(ovf_cnt), 32'd0);
        check("reset.locked", 32'(locked), 32'd0);
        check("reset.owner", 32'(owner), 32'd0);
        check("reset.gnt", 32'(bus.gnt), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int t = 0; t < 19; t++) apply(tbl[t], $sformatf("vec%0d", t));

        // Full stall and release: fill to 16 with requester 2, then stall.
        for (int k = 0; k < 9; k++) apply(mk(4'b0100, 4'b0000, 1'b0, 1'b0, 4'b0100, 8 + k, 1'b0, 0), "fill");
        apply(mk(4'b0100, 4'b0000, 1'b0, 1'b0, 4'b0000, 16, 1'b0, 0), "stall0");
        apply(mk(4'b0100, 4'b0000, 1'b0, 1'b0, 4'b0000, 16, 1'b0, 0), "stall1");
        apply(mk(4'b0100, 4'b0000, 1'b1, 1'b0, 4'b0000, 15, 1'b0, 0), "stall_pop");
        apply(mk(4'b0100, 4'b0000, 1'b0, 1'b0, 4'b0100, 16, 1'b0, 0), "release");

        // Overwrite while full, then accept+pop (not an overwrite), then saturation.
        apply(mk(4'b0010, 4'b0000, 1'b0, 1'b1, 4'b0010, 16, 1'b0, 1), "ovw1");
        apply(mk(4'b0010, 4'b0000, 1'b0, 1'b1, 4'b0010, 16, 1'b0, 2), "ovw2");
        apply(mk(4'b0010, 4'b0000, 1'b0, 1'b1, 4'b0010, 16, 1'b0, 3), "ovw3");
        apply(mk(4'b0010, 4'b0000, 1'b1, 1'b1, 4'b0010, 16, 1'b0, 3), "ovw_pop");
        for (int k = 0; k < 300; k++)
            apply(mk(4'b0010, 4'b0000, 1'b0, 1'b1, 4'b0010, 16, 1'b0, (4 + k > 255) ? 255 : 4 + k), "ovw_sat");

        // Reset asserted mid-burst clears state without waiting for a clock edge.
        apply(mk(4'b0010, 4'b0010, 1'b0, 1'b1, 4'b0010, 16, 1'b1, 255), "burst_a");
        apply(mk(4'b0010, 4'b0010, 1'b0, 1'b1, 4'b0010, 16, 1'b1, 255), "burst_b");
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("midrst.locked", 32'(locked), 32'd0);
        check("midrst.count", 32'(count), 32'd0);
        check("midrst.fifo_write", 32'(fifo_write), 32'd0);
        check("midrst.empty", 32'(empty), 32'd1);
        check("midrst.ovf_cnt", 32'(ovf_cnt), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        bus.req = 4'b0000; bus.lock = 4'b0000; overwrite_en = 1'b0; fifo_pop = 1'b0;

        // Accept+pop with count=0: pop ignored. Then count 5 with accept+pop stays 5.
        apply(mk(4'b0001, 4'b0000, 1'b1, 1'b0, 4'b0001, 1, 1'b0, 0), "acc_pop0");
        for (int k = 0; k < 4; k++) apply(mk(4'b0001, 4'b0000, 1'b0, 1'b0, 4'b0001, 2 + k, 1'b0, 0), "to5");
        apply(mk(4'b0001, 4'b0000, 1'b1, 1'b0, 4'b0001, 5, 1'b0, 0), "acc_pop5");
        apply(mk(4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 4, 1'b0, 0), "pop_only");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
